// File: rtl/hex_ascii_streamer.sv
// Hex-to-ASCII byte streamer: buffers one binary word behind a valid/ready
// handshake and emits it as ASCII hex digits, MSB nibble first, followed by
// an optional CR/LF terminator, one byte per accepted transfer.
module hex_ascii_streamer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TERM_MODE = 2,
  parameter int unsigned UPPER     = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Data_valid,
  input  logic [DATA_W-1:0] Data_in,
  output logic              Data_ready,
  input  logic              TX_ready,
  output logic              Char_valid,
  output logic [7:0]        Char_out,
  output logic              Frame_done,
  output logic              Busy
);

  localparam int unsigned NIB  = DATA_W / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NIB - 1);

  typedef enum logic [1:0] {StIdle, StHex, StTermCr, StTermLf} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_nxt;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              char_valid_q, char_valid_d;
  logic [7:0]        char_out_q, char_out_d;
  logic              frame_done_q, frame_done_d;

  logic xfer, accept, load, frame_end;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else if (UPPER != 0) begin
      return 8'h37 + {4'h0, nib};  // 'A' - 10
    end else begin
      return 8'h57 + {4'h0, nib};  // 'a' - 10
    end
  endfunction

  assign xfer   = char_valid_q & TX_ready;
  assign accept = Data_valid & ~buf_full_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a frame end with a buffered word reloads in the same edge.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: load = buf_full_q;
      StHex: begin
        if (xfer && cnt_q == '0) begin
          if (TERM_MODE == 2) begin
            state_d = StTermCr;
          end else if (TERM_MODE == 1) begin
            state_d = StTermLf;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      StTermCr: if (xfer) state_d = StTermLf;
      StTermLf: if (xfer) frame_end = 1'b1;
      default:  state_d = StIdle;
    endcase
    if (frame_end) begin
      if (buf_full_q) begin
        load = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end
    if (load) begin
      state_d = StHex;
    end
  end

  // Datapath registers: input buffer, shifter, nibble counter, output byte.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      char_valid_q <= 1'b0;
      char_out_q   <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      char_valid_q <= char_valid_d;
      char_out_q   <= char_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Datapath next values; the output byte only changes on a transfer or a load.
  always_comb begin
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    char_valid_d = char_valid_q;
    char_out_d   = char_out_q;
    frame_done_d = frame_end;
    shift_nxt    = shift_q << 4;

    if (state_q == StHex && xfer) begin
      shift_d = shift_nxt;
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q != '0) begin
        char_out_d = hex_char(shift_nxt[DATA_W-1 -: 4]);
      end
    end

    if (frame_end && !buf_full_q) begin
      char_valid_d = 1'b0;
      char_out_d   = 8'h00;
    end else if (state_d == StTermCr && state_q == StHex) begin
      char_out_d = 8'h0D;
    end else if (state_d == StTermLf && state_q != StTermLf) begin
      char_out_d = 8'h0A;
    end

    if (load) begin
      buf_full_d   = 1'b0;
      shift_d      = buf_q;
      cnt_d        = CntLast;
      char_valid_d = 1'b1;
      char_out_d   = hex_char(buf_q[DATA_W-1 -: 4]);
    end

    // Load and accept are exclusive: load needs a full buffer, accept an empty one.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_d      = Data_in;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    Data_ready = ~buf_full_q;
    Char_valid = char_valid_q;
    Char_out   = char_out_q;
    Frame_done = frame_done_q;
    Busy       = (state_q != StIdle) | buf_full_q;
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Bench for hex_ascii_streamer: three instances (16-bit CR/LF upper, 16-bit
// CR/LF lower, 32-bit no terminator) driven with directed and random words.
module tb_hex_ascii_streamer;

  logic        clk;
  logic        rst;
  logic        tx;
  logic        vld_a, vld_b;
  logic [15:0] din_a;
  logic [31:0] din_b;
  logic        rdy  [3];
  logic        cv   [3];
  logic [7:0]  co   [3];
  logic        fd   [3];
  logic        busy [3];

  int n_cmp = 0;
  int n_bad = 0;

  int   tx_mode  = 0;
  logic tx_level = 1'b1;

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] got2[$];
  int fdc0 = 0;
  int fdc1 = 0;
  int fdc2 = 0;

  logic [7:0] exp_q[$];
  int bs[3];
  int fb[3];

  logic       prev_cv [3];
  logic [7:0] prev_co [3];
  logic       prev_tx  = 1'b1;
  logic       prev_rst = 1'b1;

  hex_ascii_streamer #(.DATA_W(16), .TERM_MODE(2), .UPPER(1)) u_d0 (
    .Clk(clk), .Reset(rst), .Data_valid(vld_a), .Data_in(din_a), .Data_ready(rdy[0]),
    .TX_ready(tx), .Char_valid(cv[0]), .Char_out(co[0]), .Frame_done(fd[0]), .Busy(busy[0])
  );

  hex_ascii_streamer #(.DATA_W(16), .TERM_MODE(2), .UPPER(0)) u_d1 (
    .Clk(clk), .Reset(rst), .Data_valid(vld_a), .Data_in(din_a), .Data_ready(rdy[1]),
    .TX_ready(tx), .Char_valid(cv[1]), .Char_out(co[1]), .Frame_done(fd[1]), .Busy(busy[1])
  );

  hex_ascii_streamer #(.DATA_W(32), .TERM_MODE(0), .UPPER(1)) u_d2 (
    .Clk(clk), .Reset(rst), .Data_valid(vld_b), .Data_in(din_b), .Data_ready(rdy[2]),
    .TX_ready(tx), .Char_valid(cv[2]), .Char_out(co[2]), .Frame_done(fd[2]), .Busy(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TX_ready changes shortly after each rising edge: level, toggling, or random.
  always @(posedge clk) begin
    #2;
    case (tx_mode)
      1:       tx = ~tx;
      2:       tx = 1'($urandom_range(0, 1));
      default: tx = tx_level;
    endcase
  end

  // Byte and frame collectors.
  always @(posedge clk) begin
    if (!rst && cv[0] && tx) got0.push_back(co[0]);
    if (!rst && fd[0]) fdc0 <= fdc0 + 1;
  end
  always @(posedge clk) begin
    if (!rst && cv[1] && tx) got1.push_back(co[1]);
    if (!rst && fd[1]) fdc1 <= fdc1 + 1;
  end
  always @(posedge clk) begin
    if (!rst && cv[2] && tx) got2.push_back(co[2]);
    if (!rst && fd[2]) fdc2 <= fdc2 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int gsize(input int d);
    case (d)
      0:       return got0.size();
      1:       return got1.size();
      default: return got2.size();
    endcase
  endfunction

  function automatic logic [7:0] gat(input int d, input int i);
    case (d)
      0:       return got0[i];
      1:       return got1[i];
      default: return got2[i];
    endcase
  endfunction

  function automatic int fdget(input int d);
    case (d)
      0:       return fdc0;
      1:       return fdc1;
      default: return fdc2;
    endcase
  endfunction

  // Advance to the next falling edge; a byte stalled at the previous sample must still be held.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst && !prev_rst && prev_cv[i] && !prev_tx) begin
        chk($sformatf("d%0d_hold_valid", i), 64'(cv[i]), 64'(1));
        chk($sformatf("d%0d_hold_char", i), 64'(co[i]), 64'(prev_co[i]));
      end
      prev_cv[i] = cv[i];
      prev_co[i] = co[i];
    end
    prev_tx  = tx;
    prev_rst = rst;
  endtask

  task automatic mark();
    for (int i = 0; i < 3; i++) begin
      bs[i] = gsize(i);
      fb[i] = fdget(i);
    end
  endtask

  // Present a word (grp 0: 16-bit pair, grp 1: 32-bit) and return one edge after acceptance,
  // with valid still asserted.
  task automatic push(input int grp, input logic [31:0] w);
    int t = 0;
    int r = (grp == 0) ? 0 : 2;
    if (grp == 0) begin
      vld_a = 1'b1;
      din_a = w[15:0];
    end else begin
      vld_b = 1'b1;
      din_b = w;
    end
    while (!rdy[r] && t < 300) begin
      step();
      t++;
    end
    chk($sformatf("push%0d_ready", grp), 64'(rdy[r]), 64'(1));
    step();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy[0] || busy[1] || busy[2]) && t < 3000) begin
      step();
      t++;
    end
    chk("wait_idle", 64'(busy[0] | busy[1] | busy[2]), 64'(0));
    step();
    step();
  endtask

  // Reference: digits from the word's nibbles, MSB first, then the terminator.
  task automatic add_exp(input int d, input logic [63:0] w, input int limit);
    logic [7:0] tmp[$];
    int  nib  = (d == 2) ? 8 : 4;
    int  term = (d == 2) ? 0 : 2;
    bit  up   = (d != 1);
    for (int k = nib - 1; k >= 0; k--) begin
      int n = int'((w >> (4 * k)) & 64'hF);
      if (n < 10) tmp.push_back(8'(48 + n));
      else tmp.push_back(8'((up ? 65 : 97) + n - 10));
    end
    if (term == 2) tmp.push_back(8'h0D);
    if (term >= 1) tmp.push_back(8'h0A);
    for (int i = 0; i < tmp.size(); i++) begin
      if (limit < 0 || i < limit) exp_q.push_back(tmp[i]);
    end
  endtask

  task automatic cmp_dut(input int d, input int nfd);
    int n = gsize(d) - bs[d];
    chk($sformatf("d%0d_len", d), 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk($sformatf("d%0d_byte%0d", d, i), 64'(gat(d, bs[d] + i)), 64'(exp_q[i]));
    end
    chk($sformatf("d%0d_frames", d), 64'(fdget(d) - fb[d]), 64'(nfd));
    exp_q.delete();
  endtask

  initial begin
    int run;
    int rdy_at;
    logic [31:0] wq_a[$];
    logic [31:0] wq_b[$];

    rst   = 1'b1;
    vld_a = 1'b0;
    vld_b = 1'b0;
    din_a = '0;
    din_b = '0;
    for (int i = 0; i < 3; i++) begin
      prev_cv[i] = 1'b0;
      prev_co[i] = 8'h00;
    end
    repeat (3) step();

    // Reset values.
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_rst_ready", i), 64'(rdy[i]), 64'(1));
      chk($sformatf("d%0d_rst_cv", i), 64'(cv[i]), 64'(0));
      chk($sformatf("d%0d_rst_char", i), 64'(co[i]), 64'(0));
      chk($sformatf("d%0d_rst_fd", i), 64'(fd[i]), 64'(0));
      chk($sformatf("d%0d_rst_busy", i), 64'(busy[i]), 64'(0));
    end
    rst = 1'b0;
    step();

    // 0x1234 with TX_ready held: latency, consecutive bytes, single Frame_done.
    mark();
    push(0, 32'h1234);
    vld_a = 1'b0;
    chk("lat_cv_early", 64'(cv[0]), 64'(0));
    chk("lat_ready_low", 64'(rdy[0]), 64'(0));
    chk("lat_busy", 64'(busy[0]), 64'(1));
    step();
    chk("lat_cv_first", 64'(cv[0]), 64'(1));
    chk("lat_ready_back", 64'(rdy[0]), 64'(1));
    add_exp(0, 64'h1234, -1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("seq_cv%0d", i), 64'(cv[0]), 64'(1));
      chk($sformatf("seq_char%0d", i), 64'(co[0]), 64'(exp_q[i]));
      step();
    end
    chk("seq_cv_end", 64'(cv[0]), 64'(0));
    chk("seq_fd_pulse", 64'(fd[0]), 64'(1));
    step();
    chk("seq_fd_drop", 64'(fd[0]), 64'(0));
    wait_idle();
    cmp_dut(0, 1);
    add_exp(1, 64'h1234, -1);
    cmp_dut(1, 1);

    // 0xABCD in upper and lower case.
    mark();
    push(0, 32'hABCD);
    vld_a = 1'b0;
    wait_idle();
    add_exp(0, 64'hABCD, -1);
    cmp_dut(0, 1);
    add_exp(1, 64'hABCD, -1);
    cmp_dut(1, 1);

    // 0x00F0 with TX_ready toggling every cycle.
    tx_mode = 1;
    mark();
    push(0, 32'h00F0);
    vld_a = 1'b0;
    wait_idle();
    add_exp(0, 64'h00F0, -1);
    cmp_dut(0, 1);
    add_exp(1, 64'h00F0, -1);
    cmp_dut(1, 1);
    tx_mode  = 0;
    tx_level = 1'b1;
    step();
    step();

    // Back-to-back 0x1111, 0x2222 with valid held: no gap, ready returns after the reload.
    mark();
    push(0, 32'h1111);
    push(0, 32'h2222);
    vld_a  = 1'b0;
    run    = 0;
    rdy_at = -1;
    while (cv[0] && run < 40) begin
      if (rdy[0] && rdy_at < 0) rdy_at = run;
      run++;
      step();
    end
    chk("b2b_run", 64'(run), 64'(11));
    chk("b2b_ready_at", 64'(rdy_at), 64'(5));
    wait_idle();
    add_exp(0, 64'h1111, -1);
    add_exp(0, 64'h2222, -1);
    cmp_dut(0, 2);
    add_exp(1, 64'h1111, -1);
    add_exp(1, 64'h2222, -1);
    cmp_dut(1, 2);

    // Reset after two bytes of 0x1234 with 0x5678 buffered, then 0x9ABC.
    mark();
    push(0, 32'h1234);
    push(0, 32'h5678);
    vld_a = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_mid_rst_cv", i), 64'(cv[i]), 64'(0));
      chk($sformatf("d%0d_mid_rst_ready", i), 64'(rdy[i]), 64'(1));
      chk($sformatf("d%0d_mid_rst_busy", i), 64'(busy[i]), 64'(0));
    end
    rst = 1'b0;
    step();
    chk("post_rst_cv", 64'(cv[0]), 64'(0));
    chk("post_rst_busy", 64'(busy[0]), 64'(0));
    repeat (10) step();
    chk("post_rst_bytes", 64'(gsize(0) - bs[0]), 64'(2));
    push(0, 32'h9ABC);
    vld_a = 1'b0;
    wait_idle();
    add_exp(0, 64'h1234, 2);
    add_exp(0, 64'h9ABC, -1);
    cmp_dut(0, 1);
    add_exp(1, 64'h1234, 2);
    add_exp(1, 64'h9ABC, -1);
    cmp_dut(1, 1);

    // 32-bit, no terminator: 0xDEADBEEF.
    mark();
    push(1, 32'hDEADBEEF);
    vld_b = 1'b0;
    step();
    chk("w32_cv_first", 64'(cv[2]), 64'(1));
    add_exp(2, 64'hDEADBEEF, -1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w32_cv%0d", i), 64'(cv[2]), 64'(1));
      chk($sformatf("w32_char%0d", i), 64'(co[2]), 64'(exp_q[i]));
      step();
    end
    chk("w32_cv_end", 64'(cv[2]), 64'(0));
    chk("w32_fd_pulse", 64'(fd[2]), 64'(1));
    wait_idle();
    cmp_dut(2, 1);

    // Random words, random TX_ready, random gaps between words.
    tx_mode = 2;
    mark();
    for (int j = 0; j < 6; j++) begin
      wq_a.push_back(32'($urandom) & 32'hFFFF);
      push(0, wq_a[j]);
      vld_a = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    for (int j = 0; j < 5; j++) begin
      wq_b.push_back(32'($urandom));
      push(1, wq_b[j]);
      vld_b = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < wq_a.size(); j++) add_exp(d, 64'(wq_a[j]), -1);
      cmp_dut(d, wq_a.size());
    end
    for (int j = 0; j < wq_b.size(); j++) add_exp(2, 64'(wq_b[j]), -1);
    cmp_dut(2, wq_b.size());
    tx_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_ascii_streamer.md
Name: hex_ascii_streamer

Overview:
- Parametrised successor to the team's fixed 16-bit hex-to-ASCII converter.
- Accepts binary words of configurable width through a valid/ready handshake and buffers one word while the previous word is still being sent.
- Emits one ASCII hex digit per transfer, MSB nibble first, followed by an optional line terminator, with selectable upper or lower case.
- Sits between measurement logic (e.g. tic-toc timers) and the UART transmitter; TX_ready is the UART's byte-accept signal.

Parameters:
- DATA_W, 16, input word width in bits; must be a multiple of 4 and in the range 4..64. NIB = DATA_W/4.
- TERM_MODE, 2, terminator: 0 = none, 1 = LF (0x0A), 2 = CR (0x0D) then LF (0x0A).
- UPPER, 1, case of digits A-F: 1 = 0x41-0x46, 0 = 0x61-0x66.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Data_valid  in  1  producer presents a word on Data_in.
- Data_in  in  DATA_W  word to print.
- Data_ready  out  1  input buffer empty; the word is accepted when Data_valid and Data_ready are both high at a Clk edge.
- TX_ready  in  1  UART can accept a byte this cycle.
- Char_valid  out  1  Char_out holds a valid byte.
- Char_out  out  8  ASCII byte; transferred when Char_valid and TX_ready are both high.
- Frame_done  out  1  one-cycle pulse in the cycle after the last byte of a frame transfers.
- Busy  out  1  high while the serializer is sending a frame or the buffer holds a word.

Behaviour:
- Reset values: Data_ready=1, Char_valid=0, Char_out=0x00, Frame_done=0, Busy=0. The buffer is emptied and the state is IDLE.
- Reset mid-frame:
  - The partial frame and any buffered word are discarded; no further bytes of the old frame are emitted.
  - Reset has priority over every other event in the same cycle.
- Input buffer: one entry.
  - Data_ready = not buf_full (registered).
  - A word accepted at edge N sets buf_full, so Data_ready=0 from cycle N+1.
  - No fill and drain of the buffer in the same cycle: while buf_full, Data_ready=0.
- Serializer FSM states: IDLE, HEX, TERM_CR, TERM_LF.
  - IDLE, buf_full=1: load the buffer into the shift register, clear buf_full, set nib_cnt=NIB-1, go to HEX. Char_valid=1 with the MSB-nibble character from the next cycle.
    - First byte latency: word accepted at edge N, buffer loaded at edge N+1, Char_valid=1 in cycle N+2.
  - HEX, on transfer: shift left 4 and decrement nib_cnt.
    - If nib_cnt was 0: go to TERM_CR (TERM_MODE=2), TERM_LF (TERM_MODE=1), or end the frame (TERM_MODE=0).
  - TERM_CR, on transfer: go to TERM_LF.
  - TERM_LF, on transfer: end the frame.
  - End of frame:
    - Pulse Frame_done.
    - If buf_full: load the next word in the same edge and go to HEX, so the next frame follows with no idle cycle when TX_ready stays 1.
    - Otherwise: Char_valid=0 and go to IDLE.
- Character mapping: nibble 0-9 -> 0x30-0x39; nibble 10-15 -> 0x41-0x46 (UPPER=1) or 0x61-0x66 (UPPER=0).
- Output rules:
  - Char_out is registered.
  - While Char_valid=1 and TX_ready=0, Char_out and Char_valid must hold stable.
  - Char_valid never drops without a transfer, except on Reset.
- Throughput: one byte per cycle while TX_ready=1.
- Frame length: NIB + (0, 1 or 2) bytes for TERM_MODE 0, 1 or 2.
- Busy = (state != IDLE) or buf_full.

Test Plan:
- Defaults (DATA_W=16, TERM_MODE=2, UPPER=1), TX_ready held 1, one word 0x1234 -> bytes 0x31,0x32,0x33,0x34,0x0D,0x0A on consecutive cycles; first Char_valid two cycles after acceptance; one Frame_done pulse.
- Word 0xABCD with UPPER=1 -> 0x41,0x42,0x43,0x44,0x0D,0x0A. Same word with UPPER=0 -> 0x61,0x62,0x63,0x64,0x0D,0x0A.
- TX_ready toggled every 10 ns (period 20 ns), word 0x00F0 -> 0x30,0x30,0x46,0x30,0x0D,0x0A; each byte held stable across TX_ready-low cycles; no byte duplicated or skipped.
- Back-to-back words 0x1111 then 0x2222 with Data_valid held and TX_ready=1 -> 12 bytes with no Char_valid gap; Data_ready rises again after the second word is loaded; Frame_done pulses twice.
- Reset asserted for one cycle after two bytes of 0x1234, with 0x5678 buffered -> Char_valid=0, Data_ready=1, Busy=0 the cycle after; no further bytes from either word; a new word 0x9ABC afterwards prints correctly.
- DATA_W=32, TERM_MODE=0, word 0xDEADBEEF -> exactly 8 bytes 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46; Frame_done one cycle after the 8th transfer.
